pwm_duty_capture: RTL and testbench

- Receive-side counterpart to the DPWM generator: measures an incoming PWM waveform and recovers its duty word and period in clk cycles.
- Used for closed-loop self-check of the DPWM output and for reading back gate-drive feedback.
- Input is asynchronous. Outputs are registered and accompanied by a one-cycle valid strobe per completed period.

---
 rtl/pwm_duty_capture.sv | 153 +++++++++++++++
 tb/tb_pwm_duty_capture.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_duty_capture.sv
// pwm_duty_capture
// Measures an asynchronous PWM input and recovers its period and high-time.
// Both are counted in clk cycles between consecutive synchronized rising edges.
// The recovered values are presented together with a one-cycle valid strobe.
// A missing rising edge for the full counter range raises a sticky err_stuck flag.
module pwm_duty_capture #(
    parameter int DUTY_W     = 6,
    parameter int PER_W      = 8,
    parameter int NOM_PERIOD = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pwm_in,
    input  logic              enable,
    output logic [DUTY_W-1:0] duty_out,
    output logic [PER_W-1:0]  period_out,
    output logic              valid,
    output logic              err_period,
    output logic              err_stuck
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        MEASURE = 2'd2
    } state_t;

    localparam logic [PER_W-1:0] CNT_MAX   = '1;
    localparam logic [PER_W-1:0] DUTY_SAT  = PER_W'((1 << DUTY_W) - 1);
    localparam logic [PER_W-1:0] NOM_CNT   = PER_W'(NOM_PERIOD);
    localparam logic [PER_W-1:0] CNT_ONE   = PER_W'(1);

    // Synchronizer and history flops
    logic s1_q, s2_q, s3_q;
    logic rise;

    state_t             state_q, state_d;
    logic [PER_W-1:0]   per_cnt_q, per_cnt_d;
    logic [PER_W-1:0]   hi_cnt_q, hi_cnt_d;
    logic [DUTY_W-1:0]  duty_q, duty_d;
    logic [PER_W-1:0]   period_q, period_d;
    logic               valid_q, valid_d;
    logic               err_period_q, err_period_d;
    logic               err_stuck_q, err_stuck_d;

    // Two-flop synchronizer on the asynchronous input, plus one history flop for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= pwm_in;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign rise = s2_q & ~s3_q;

    // State, counter and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            per_cnt_q    <= '0;
            hi_cnt_q     <= '0;
            duty_q       <= '0;
            period_q     <= '0;
            valid_q      <= 1'b0;
            err_period_q <= 1'b0;
            err_stuck_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            per_cnt_q    <= per_cnt_d;
            hi_cnt_q     <= hi_cnt_d;
            duty_q       <= duty_d;
            period_q     <= period_d;
            valid_q      <= valid_d;
            err_period_q <= err_period_d;
            err_stuck_q  <= err_stuck_d;
        end
    end

    // Next-state logic: arm on the first edge, then capture on every later edge or time out
    always_comb begin
        state_d      = state_q;
        per_cnt_d    = per_cnt_q;
        hi_cnt_d     = hi_cnt_q;
        duty_d       = duty_q;
        period_d     = period_q;
        valid_d      = 1'b0;
        err_period_d = err_period_q;
        err_stuck_d  = err_stuck_q;

        if (!enable) begin
            // Disabling abandons the measurement in progress but keeps the last results
            state_d   = IDLE;
            per_cnt_d = '0;
            hi_cnt_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    per_cnt_d = '0;
                    hi_cnt_d  = '0;
                    state_d   = ARM;
                end
                ARM: begin
                    // The partial period before the first edge is unknown, so it is not reported
                    if (rise) begin
                        per_cnt_d = CNT_ONE;
                        hi_cnt_d  = CNT_ONE;
                        state_d   = MEASURE;
                    end
                end
                MEASURE: begin
                    if (rise) begin
                        // An edge takes priority over a timeout in the same cycle
                        period_d     = per_cnt_q;
                        duty_d       = (hi_cnt_q > DUTY_SAT) ? '1 : hi_cnt_q[DUTY_W-1:0];
                        err_period_d = (per_cnt_q != NOM_CNT);
                        err_stuck_d  = 1'b0;
                        valid_d      = 1'b1;
                        per_cnt_d    = CNT_ONE;
                        hi_cnt_d     = CNT_ONE;
                    end else if (per_cnt_q == CNT_MAX) begin
                        // A constant input level produces no edges and ends up here
                        err_stuck_d = 1'b1;
                        per_cnt_d   = '0;
                        hi_cnt_d    = '0;
                        state_d     = ARM;
                    end else begin
                        per_cnt_d = per_cnt_q + CNT_ONE;
                        if (s2_q && (hi_cnt_q != CNT_MAX)) begin
                            hi_cnt_d = hi_cnt_q + CNT_ONE;
                        end
                    end
                end
                default: begin
                    state_d   = IDLE;
                    per_cnt_d = '0;
                    hi_cnt_d  = '0;
                end
            endcase
        end
    end

    assign duty_out   = duty_q;
    assign period_out = period_q;
    assign valid      = valid_q;
    assign err_period = err_period_q;
    assign err_stuck  = err_stuck_q;

endmodule

// File: tb/tb_pwm_duty_capture.sv
// Bench for pwm_duty_capture.
// PWM stimulus pushes the expected capture of each completed period into a queue.
// A monitor on valid pops the queue and compares the DUT outputs.
module tb_pwm_duty_capture;

    logic       clk;
    logic       rst;
    logic       pwm_in;
    logic       enable;
    logic [5:0] duty_out;
    logic [7:0] period_out;
    logic       valid;
    logic       err_period;
    logic       err_stuck;

    pwm_duty_capture #(
        .DUTY_W    (6),
        .PER_W     (8),
        .NOM_PERIOD(64)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pwm_in    (pwm_in),
        .enable    (enable),
        .duty_out  (duty_out),
        .period_out(period_out),
        .valid     (valid),
        .err_period(err_period),
        .err_stuck (err_stuck)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int duty;
        int per;
        int errp;
    } exp_t;

    exp_t exp_q[$];
    exp_t last_e;

    int n_tests = 0;
    int n_fail  = 0;
    int n_valid = 0;
    logic valid_last = 1'b0;

    bit have_prev = 1'b0;
    int prev_h = 0;
    int prev_l = 0;

    task automatic check(input string name, input int act, input int expv);
        n_tests++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
        end else begin
            $display("[TB] ok %s = %0d", name, act);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One PWM period: rising edge, h cycles high, l cycles low.
    // The rising edge completes the previous period, so its capture is expected now.
    task automatic pwm_period(input int h, input int l);
        exp_t e;
        pwm_in = 1'b1;
        if (have_prev) begin
            e.duty = (prev_h > 63) ? 63 : prev_h;
            e.per  = prev_h + prev_l;
            e.errp = (e.per != 64) ? 1 : 0;
            exp_q.push_back(e);
            last_e = e;
        end
        have_prev = 1'b1;
        prev_h    = h;
        prev_l    = l;
        tick(h);
        pwm_in = 1'b0;
        tick(l);
    endtask

    // Monitor: every valid must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (valid) begin
            n_valid++;
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_valid: got valid=1 duty=%0d period=%0d, expected no valid (t=%0t)",
                         duty_out, period_out, $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                $display("[TB] capture duty=%0d period=%0d err_period=%0d err_stuck=%0d",
                         duty_out, period_out, err_period, err_stuck);
                check("duty_out", int'(duty_out), e.duty);
                check("period_out", int'(period_out), e.per);
                check("err_period", int'(err_period), e.errp);
                check("err_stuck_on_valid", int'(err_stuck), 0);
                check("valid_single_cycle", int'(valid_last), 0);
            end
        end
        valid_last = valid;
    end

    int vcount;

    initial begin
        rst    = 1'b1;
        pwm_in = 1'b0;
        enable = 1'b0;
        tick(3);
        check("reset_duty", int'(duty_out), 0);
        check("reset_period", int'(period_out), 0);
        check("reset_valid", int'(valid), 0);
        check("reset_err_stuck", int'(err_stuck), 0);
        rst = 1'b0;
        tick(2);
        enable = 1'b1;
        tick(5);

        // Nominal 20/64 waveform; first capture only after the second edge
        for (int i = 0; i < 4; i++) pwm_period(20, 44);

        // DPWM-like duty words at the nominal period, including the extremes
        pwm_period(1, 63);
        pwm_period(2, 62);
        pwm_period(31, 33);
        pwm_period(62, 2);

        // Long period with long high-time: duty saturates, period error flagged
        pwm_period(80, 20);
        pwm_period(80, 20);

        // Stuck high: the edge closes the last 80/20 period, then nothing
        begin
            exp_t e;
            pwm_in = 1'b1;
            e.duty = 63;
            e.per  = 100;
            e.errp = 1;
            exp_q.push_back(e);
            last_e = e;
            have_prev = 1'b0;
            tick(240);
            check("stuck_not_yet", int'(err_stuck), 0);
            vcount = n_valid;
            tick(60);
            check("stuck_flag", int'(err_stuck), 1);
            check("stuck_no_valid", n_valid - vcount, 0);
            check("stuck_hold_duty", int'(duty_out), 63);
            check("stuck_hold_period", int'(period_out), 100);
            check("stuck_hold_err_period", int'(err_period), 1);
            pwm_in = 1'b0;
            tick(20);
        end

        // Resume: first edge only re-arms, err_stuck clears with the next valid
        pwm_period(20, 44);
        check("stuck_held_after_arm", int'(err_stuck), 1);
        pwm_period(20, 44);
        check("stuck_cleared", int'(err_stuck), 0);

        // Drop enable mid-period; results hold and no valid is produced
        pwm_in = 1'b1;
        begin
            exp_t e;
            e.duty = 20;
            e.per  = 64;
            e.errp = 0;
            exp_q.push_back(e);
            last_e = e;
        end
        have_prev = 1'b0;
        tick(10);
        enable = 1'b0;
        vcount = n_valid;
        tick(15);
        pwm_in = 1'b0;
        tick(15);
        pwm_in = 1'b1;
        tick(15);
        pwm_in = 1'b0;
        tick(15);
        check("disabled_no_valid", n_valid - vcount, 0);
        check("disabled_hold_duty", int'(duty_out), last_e.duty);
        check("disabled_hold_period", int'(period_out), last_e.per);
        check("disabled_hold_err_period", int'(err_period), last_e.errp);
        enable = 1'b1;
        tick(5);
        for (int i = 0; i < 3; i++) pwm_period(30, 34);

        // Asynchronous reset in the middle of a measurement
        pwm_in = 1'b1;
        begin
            exp_t e;
            e.duty = 30;
            e.per  = 64;
            e.errp = 0;
            exp_q.push_back(e);
        end
        have_prev = 1'b0;
        tick(10);
        check("pre_reset_duty", int'(duty_out), 30);
        #2;
        rst = 1'b1;
        #1;
        check("async_reset_duty", int'(duty_out), 0);
        check("async_reset_period", int'(period_out), 0);
        check("async_reset_valid", int'(valid), 0);
        check("async_reset_err_period", int'(err_period), 0);
        check("async_reset_err_stuck", int'(err_stuck), 0);
        check("pending_before_reset", exp_q.size(), 0);
        pwm_in = 1'b0;
        tick(3);
        rst = 1'b0;
        tick(5);
        for (int i = 0; i < 3; i++) pwm_period(20, 44);

        // All expected captures must have been observed
        tick(10);
        check("queue_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
